uart_rx: RTL and testbench

Serial receiver for the UART path, the receive end of the 16x-oversampled 8N1 link driven by the transmitter in this design. It synchronises the asynchronous `rx` line, detects the start bit, samples each data bit at mid-bit using the shared baud-rate `s_tick`, checks the stop bit, and presents the received byte with a one-cycle completion pulse. It sits between the pad input and the receive FIFO or interface logic.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports: clk, reset (async, active-high), d (async in), q (synchronised out).
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] ff_q;
  logic [1:0] ff_d;

  always_comb ff_d = {ff_q[0], d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff_q <= {2{RST_VAL}};
    else       ff_q <= ff_d;
  end

  assign q = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (start + DBIT data + optional even parity
// + stop). Ports: clk, reset (async high), rx, s_tick -> dout,
// rx_done_tick, frame_err, parity_err (only with UART_RX_PARITY_EN).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       frame_err
);

  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0]    AFTER_DATA = PARITY;
`else
  localparam logic [2:0]    AFTER_DATA = STOP;
`endif

  logic          rx_s;
  logic [2:0]    state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    b_q, b_d;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      // Start detection is ungated so the falling edge is caught
      // within one clk, not one tick.
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s, b_q[7:1]};
            if (n_q == N_LAST) state_d = AFTER_DATA;
            else               n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            par_bad_d = rx_s ^ (^b_q[7:8-DBIT]);
            s_d       = '0;
            state_d   = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == S_LAST) state_d = IDLE;
          else               s_d     = s_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Mealy completion pulses, valid only in the final stop tick.
  always_comb begin
    rx_done_tick = 1'b0;
    frame_err    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err   = 1'b0;
`endif
    if (s_tick && state_q == STOP && s_q == S_LAST) begin
      rx_done_tick = 1'b1;
      frame_err    = ~rx_s;
`ifdef UART_RX_PARITY_EN
      parity_err   = par_bad_q;
`endif
    end
  end

  assign dout = b_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, corner sequences
// and random frames against a queue-based frame model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;
  int unsigned tdiv = 0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] dout;
    logic       ferr;
    logic       perr;
  } res_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         gap;
    logic [7:0] e_dout;
    logic       e_ferr;
    logic       e_perr;
  } vec_t;

  res_t exp_q[$];
  res_t cap_q[$];
  vec_t tbl[6];

`ifdef UART_RX_PARITY_EN
  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );
`else
  assign parity_err = 1'b0;
  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );
`endif

  always #5 clk = ~clk;

  // Baud generator: one tick every 3 clk.
  always @(posedge clk) begin
    if (tdiv == 2) begin
      tdiv   <= 0;
      s_tick <= 1'b1;
    end else begin
      tdiv   <= tdiv + 1;
      s_tick <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_done_tick) begin
      cap_q.push_back('{dout, frame_err, parity_err});
    end
    if ((frame_err || parity_err) && !rx_done_tick) begin
      n_checks++;
      n_fail++;
      $display("FAIL err_gating: ferr=%0b perr=%0b done=0 required 0",
               frame_err, parity_err);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(int n);
    repeat (n) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(logic b);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(logic [7:0] d, logic par, logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par) rx = 1'b1;
`endif
    send_bit(stop);
    rx = 1'b1;
  endtask

  // Behavioural model: a frame yields its byte, an error if the stop
  // bit was low, and (even parity) an error if the ones count is odd.
  function automatic res_t model(logic [7:0] d, logic par, logic stop);
    res_t r;
    r.dout = d;
    r.ferr = ~stop;
`ifdef UART_RX_PARITY_EN
    r.perr = par ^ (^d);
`else
    r.perr = 1'b0;
`endif
    return r;
  endfunction

  task automatic drain(string tag);
    res_t c;
    res_t e;
    chk({tag, "_count"}, cap_q.size(), exp_q.size());
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_dout"}, c.dout, e.dout);
      chk({tag, "_ferr"}, c.ferr, e.ferr);
      chk({tag, "_perr"}, c.perr, e.perr);
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    res_t       r;
    logic [7:0] d;
    logic       p;
    logic       s;
    int         g;

    tbl[0] = '{8'h55, 1'b0, 1'b1, 4,  8'h55, 1'b0, 1'b0};
    tbl[1] = '{8'hA3, 1'b0, 1'b1, 16, 8'hA3, 1'b0, 1'b0};
    tbl[2] = '{8'h0F, 1'b0, 1'b1, 0,  8'h0F, 1'b0, 1'b0};
    tbl[3] = '{8'h81, 1'b0, 1'b0, 16, 8'h81, 1'b1, 1'b0};
    tbl[4] = '{8'h07, 1'b0, 1'b1, 20, 8'h07, 1'b0, 1'b1};
    tbl[5] = '{8'h07, 1'b1, 1'b1, 20, 8'h07, 1'b0, 1'b0};

    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_dout", dout, 8'h00);
    chk("reset_done", rx_done_tick, 1'b0);
    chk("reset_ferr", frame_err, 1'b0);
    chk("reset_perr", parity_err, 1'b0);

    foreach (tbl[i]) begin
      rx = 1'b1;
      wait_ticks(tbl[i].gap);
`ifdef UART_RX_PARITY_EN
      exp_q.push_back('{tbl[i].e_dout, tbl[i].e_ferr, tbl[i].e_perr});
`else
      exp_q.push_back('{tbl[i].e_dout, tbl[i].e_ferr, 1'b0});
`endif
      send_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
      drain($sformatf("tbl%0d", i));
    end

    // Start glitch shorter than half a bit is rejected.
    wait_ticks(20);
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(24);
    drain("glitch");
    exp_q.push_back(model(8'h3C, 1'b0, 1'b1));
    send_frame(8'h3C, 1'b0, 1'b1);
    drain("after_glitch");

    // Reset after the third data bit aborts the frame silently.
    wait_ticks(10);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b1;
    reset = 1'b1;
    wait_ticks(2);
    reset = 1'b0;
    #1;
    chk("midreset_dout", dout, 8'h00);
    wait_ticks(20);
    drain("midreset");
    exp_q.push_back(model(8'hC6, 1'b0, 1'b1));
    send_frame(8'hC6, 1'b0, 1'b1);
    drain("after_reset");

    for (int k = 0; k < 20; k++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 9) != 0);
      g = s ? $urandom_range(0, 8) : 16 + $urandom_range(0, 8);
      rx = 1'b1;
      wait_ticks(g);
      r = model(d, p, s);
      exp_q.push_back(r);
      send_frame(d, p, s);
      if (!s) begin
        rx = 1'b1;
        wait_ticks(16);
      end
      drain($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
